// File: rtl/demux2_pkg.sv
// demux2_pkg: shared constants and types for the 1-to-2 stream demultiplexer.
// Optional per-channel transfer counters are compiled in with DEMUX2_CNT_EN.
package demux2_pkg;

  // Default data width of every channel
  localparam int unsigned DEMUX2_WIDTH = 4;

  // Number of sink channels
  localparam int unsigned NUM_CH = 2;

  // Channel index / select values
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Holding-slot state
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : demux2_pkg

// File: rtl/demux2_slot.sv
// demux2_slot: one-entry holding register with a valid/ready output handshake.
// A load while FULL and draining overlaps the two, giving 1 word/cycle.
// With DEMUX2_CNT_EN a wrapping counter tallies completed output transfers.
module demux2_slot
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX2_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] yout,
  output logic             valid,
  input  logic             ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt,
  input  logic             cnt_clr
`endif
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             drain;

  assign drain = (state_q == FULL) && ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Next state: a load always leaves the slot FULL; a bare drain empties it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load)       state_d = FULL;
      FULL:  if (load)       state_d = FULL;
             else if (ready) state_d = EMPTY;
      default:               state_d = EMPTY;
    endcase
  end

  // Output decode: valid is exactly the FULL state
  always_comb begin
    valid = (state_q == FULL);
  end

  // Data holding register; only a load may change it, so data is stable under stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  data_q <= '0;
    else if (load) data_q <= din;
  end

  assign yout = data_q;

`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter next value: clear wins over a same-cycle drain; natural wrap
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)    cnt_d = '0;
    else if (drain) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  // Counter width is only meaningful when counters are compiled in
  logic unused_slot;
  assign unused_slot = ^{CNT_W, drain};
`endif

endmodule : demux2_slot

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer.
// The select bit steers each source word into one of two holding slots; each
// slot stalls independently. d_ready looks only at the selected slot.
// Optional macro: DEMUX2_CNT_EN adds cnt0/cnt1/cnt_clr transfer counters.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX2_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  input  logic             cnt_clr
`endif
);

  logic [NUM_CH-1:0][WIDTH-1:0] ch_y;
  logic [NUM_CH-1:0]            ch_vld;
  logic [NUM_CH-1:0]            ch_rdy;
  logic [NUM_CH-1:0]            ch_ld;
`ifdef DEMUX2_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;
`endif

  assign ch_rdy[CH0] = y0_ready;
  assign ch_rdy[CH1] = y1_ready;

  // Source ready: the selected slot has room now or frees up this cycle
  always_comb begin
    d_ready = !ch_vld[s] || ch_rdy[s];
  end

  // Select decode: at most one slot loads per cycle
  always_comb begin
    ch_ld      = '0;
    ch_ld[CH0] = d_valid && d_ready && (s == CH0);
    ch_ld[CH1] = d_valid && d_ready && (s == CH1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux2_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (ch_ld[g]),
      .din     (d),
      .yout    (ch_y[g]),
      .valid   (ch_vld[g]),
      .ready   (ch_rdy[g])
`ifdef DEMUX2_CNT_EN
      ,
      .cnt     (ch_cnt[g]),
      .cnt_clr (cnt_clr)
`endif
    );
  end

  assign y0       = ch_y[CH0];
  assign y1       = ch_y[CH1];
  assign y0_valid = ch_vld[CH0];
  assign y1_valid = ch_vld[CH1];

`ifdef DEMUX2_CNT_EN
  assign cnt0 = ch_cnt[CH0];
  assign cnt1 = ch_cnt[CH1];
`endif

endmodule : demux2_stream

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed self-checking bench for demux2_stream.
// Counter checks are compiled in together with DEMUX2_CNT_EN (CNT_W=2).
module tb_demux2_stream;

  localparam int unsigned W   = 4;
  localparam int unsigned CW  = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] d;
  logic         s;
  logic         d_valid;
  logic         d_ready;
  logic [W-1:0] y0, y1;
  logic         y0_valid, y1_valid;
  logic         y0_ready, y1_ready;
`ifdef DEMUX2_CNT_EN
  logic [CW-1:0] cnt0, cnt1;
  logic          cnt_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d        (d),
    .s        (s),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .y0       (y0),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt_clr  (cnt_clr)
`endif
  );

  // Advance one active edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d = '0; s = 1'b0; d_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
`ifdef DEMUX2_CNT_EN
    cnt_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    n_tests++;
    if ({y0, y0_valid, y1, y1_valid} !== {4'h0, 1'b0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got y0=%h v0=%b y1=%h v1=%b want all 0", y0, y0_valid, y1, y1_valid);
    end
    n_tests++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_d_ready: got %b want 1", d_ready);
    end
`ifdef DEMUX2_CNT_EN
    n_tests++;
    if ({cnt0, cnt1} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got cnt0=%0d cnt1=%0d want 0 0", cnt0, cnt1);
    end
`endif
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    d = 4'hA; s = 1'b0; d_valid = 1'b1; y0_ready = 1'b1;
    #1;
    n_tests++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_d_ready: got %b want 1", d_ready);
    end
    step();
    d_valid = 1'b0;
    n_tests++;
    if ({y0, y0_valid, y1_valid} !== {4'hA, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_load: got y0=%h v0=%b v1=%b want A 1 0", y0, y0_valid, y1_valid);
    end
    step();
    n_tests++;
    if (y0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got v0=%b want 0", y0_valid);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    // Fill channel 0 with 3 while its consumer stalls
    d = 4'h3; s = 1'b0; d_valid = 1'b1; y0_ready = 1'b0;
    step();
    d = 4'h5;
    #1;
    n_tests++;
    if (d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_d_ready: got %b want 0", d_ready);
    end
    step();
    n_tests++;
    if ({y0, y0_valid} !== {4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_hold: got y0=%h v0=%b want 3 1", y0, y0_valid);
    end
    s = 1'b1;
    #1;
    n_tests++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_other_ready: got %b want 1", d_ready);
    end
    step();
    d_valid = 1'b0;
    n_tests++;
    if ({y1, y1_valid, y0, y0_valid} !== {4'h5, 1'b1, 4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_route: got y1=%h v1=%b y0=%h v0=%b want 5 1 3 1", y1, y1_valid, y0, y0_valid);
    end
    y0_ready = 1'b1; y1_ready = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    s = 1'b1; y1_ready = 1'b1; d_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      w = W'(i);
      d = w;
      #1;
      n_tests++;
      if (d_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_d_ready[%0d]: got %b want 1", i, d_ready);
      end
      step();
      n_tests++;
      if ({y1, y1_valid} !== {w, 1'b1}) begin
        n_fail++;
        $display("FAIL stream_word[%0d]: got y1=%h v1=%b want %h 1", i, y1, y1_valid, w);
      end
    end
    d_valid = 1'b0;
    step();
    n_tests++;
    if (y1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_empty: got v1=%b want 0", y1_valid);
    end
    idle_inputs();
  endtask

  task automatic test_simul_drain();
    d = 4'h6; s = 1'b0; d_valid = 1'b1;
    step();
    d = 4'h9; s = 1'b1;
    step();
    d_valid = 1'b0;
    n_tests++;
    if ({y0, y0_valid, y1, y1_valid} !== {4'h6, 1'b1, 4'h9, 1'b1}) begin
      n_fail++;
      $display("FAIL dual_full: got y0=%h v0=%b y1=%h v1=%b want 6 1 9 1", y0, y0_valid, y1, y1_valid);
    end
    y0_ready = 1'b1; y1_ready = 1'b1;
    step();
    n_tests++;
    if ({y0_valid, y1_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL dual_drain: got v0=%b v1=%b want 0 0", y0_valid, y1_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    d = 4'hF; s = 1'b1; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    n_tests++;
    if ({y1, y1_valid} !== {4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_pre: got y1=%h v1=%b want F 1", y1, y1_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({y1, y1_valid} !== {4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_async: got y1=%h v1=%b want 0 0", y1, y1_valid);
    end
    #1;
    reset_n = 1'b1;
    idle_inputs();
    step();
  endtask

`ifdef DEMUX2_CNT_EN
  task automatic test_counter();
    logic [CW-1:0] exp;
    do_reset();
    exp = '0;
    for (int i = 0; i < 5; i++) begin
      d = W'(i); s = 1'b0; d_valid = 1'b1; y0_ready = 1'b0;
      step();
      d_valid = 1'b0; y0_ready = 1'b1;
      step();
      y0_ready = 1'b0;
      exp = exp + 1'b1;
      n_tests++;
      if (cnt0 !== exp) begin
        n_fail++;
        $display("FAIL cnt0_seq[%0d]: got %0d want %0d", i, cnt0, exp);
      end
    end
    d_valid = 1'b1;
    step();
    d_valid = 1'b0; y0_ready = 1'b1; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_tests++;
    if ({cnt0, cnt1, y0_valid} !== {2'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL cnt_clr: got cnt0=%0d cnt1=%0d v0=%b want 0 0 0", cnt0, cnt1, y0_valid);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_simul_drain();
    test_reset_mid();
`ifdef DEMUX2_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux2_stream

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer: the distribution counterpart to the 2-to-1 mux in the alu4 datapath. A single WIDTH-bit source stream is steered by a per-word select bit to one of two sink channels. Each sink has a one-entry holding register with a valid/ready handshake. It sits between the ALU result stage and two consumers, such as a register writeback path and a flag/status path, so that either consumer can stall independently.

## Interface
- WIDTH, 4, data width of every channel
- CNT_W, 8, width of per-channel transfer counters (used only when the counter feature is compiled in)

- clk  in  1  rising-edge clock, sole clock domain
- reset_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- d  in  WIDTH  source data word
- s  in  1  select: 0 routes d to channel 0, 1 routes d to channel 1
- d_valid  in  1  source word and s are valid this cycle
- d_ready  out  1  block accepts the source word this cycle
- y0  out  WIDTH  channel 0 data
- y0_valid  out  1  channel 0 holds a word
- y0_ready  in  1  channel 0 consumer accepts
- y1  out  WIDTH  channel 1 data
- y1_valid  out  1  channel 1 holds a word
- y1_ready  in  1  channel 1 consumer accepts
- cnt0, cnt1  out  CNT_W  completed output transfers per channel (present only with DEMUX2_CNT_EN)
- cnt_clr  in  1  synchronous counter clear (present only with DEMUX2_CNT_EN)

## Operation
- Each channel is a two-state FSM with states EMPTY and FULL. yN_valid is 1 exactly when channel N is FULL.
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY when a drain happens without a simultaneous load.
  - FULL -> FULL when a drain and a load happen in the same cycle; the new word replaces the old one.
- Drain N: yN_valid && yN_ready.
- Load N: d_valid && d_ready && s==N. The register captures yN <= d.
- d_ready is combinational: d_ready = !yN_valid || yN_ready, where N = s.
  - d_ready depends only on the selected channel. A stalled non-selected channel never blocks the source.
- The non-selected channel is untouched by a load. Both channels may drain in the same cycle.
- yN holds its value while FULL and not drained. Data does not change while valid && !ready.
- When d_valid=0, d_ready still reflects the selected channel, and no load occurs.
- Reset values: y0=y1=0, y0_valid=y1_valid=0, both FSMs EMPTY, cnt0=cnt1=0.
- Reset asserted mid-operation discards held words immediately and asynchronously; outputs go to their reset values.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on yN with yN_valid=1 after edge k.
- Throughput per channel is 1 word/cycle when the consumer holds yN_ready=1 continuously, because load and drain overlap.
- There is no combinational path from d to yN. The only combinational paths are yN_ready/s -> d_ready.
- Source rule: once d_valid=1, d and s must not change until d_ready=1.

## Configuration
- Macro: DEMUX2_CNT_EN.
- Defined:
  - Ports cnt0, cnt1 and cnt_clr exist.
  - cntN increments by 1 on each drain N and wraps from 2^CNT_W-1 to 0.
  - cnt_clr=1 clears both counters on the next edge and takes priority over a same-cycle increment.
- Undefined: the ports and counter logic are absent. Datapath behaviour is identical.

## Structure
- Package demux2_pkg holds:
  - the default WIDTH constant (4);
  - the slot state typedef (EMPTY=1'b0, FULL=1'b1);
  - the channel index constants CH0=0, CH1=1.
- Sub-module demux2_slot is one holding register plus FSM, optionally with its counter.
  - Ports: clk, reset_n, load, din, yout, valid, ready, and cnt/cnt_clr under the macro.
  - The top level instantiates it twice and contains the select decode and d_ready logic.

## Test plan
- After reset: d=4'hA, s=0, d_valid=1, y0_ready=1 -> d_ready=1; next cycle y0=4'hA, y0_valid=1, y1_valid=0.
- Channel 0 stalled: y0_ready=0 with channel 0 FULL holding 4'h3, then s=0, d=4'h5 -> d_ready=0 and y0 stays 4'h3. Switch to s=1 -> d_ready=1 and next cycle y1=4'h5.
- Streaming: s=1, words 1,2,3,4 on consecutive cycles, y1_ready=1 -> d_ready stays 1 and y1 shows 1,2,3,4 one cycle later, back-to-back.
- Simultaneous drain: both channels FULL (y0=4'h6, y1=4'h9) with y0_ready=y1_ready=1 and d_valid=0 -> both valids go to 0 on the next edge.
- Reset mid-operation: channel 1 FULL with 4'hF, pulse reset_n low between edges -> y1_valid=0 and y1=0 immediately, without waiting for a clock edge.
- With DEMUX2_CNT_EN, CNT_W=2: five channel 0 drains -> cnt0 sequence 1,2,3,0,1. Assert cnt_clr during a drain -> cnt0=0.
